// File: rtl/rbus_axi_pkg.sv
// Shared AXI constants, burst-length helper and engine state encodings for the rbus AXI slaves.
package rbus_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B     = 3'b011;

  // Nominal AXI len (beats minus one) for a burst of burst_bits on a 64-bit bus.
  function automatic logic [7:0] axi_len_nom(input int unsigned burst_bits);
    return 8'(burst_bits / 64 - 1);
  endfunction

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

endpackage

// File: rtl/axi_bram_dp.sv
// Simple dual-port RAM, 64-bit words: byte-enabled write port, registered read port with enable.
// Read-first: a same-cycle read of the word being written returns the old contents.
module axi_bram_dp #(
  parameter int unsigned AW = 12
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [7:0]    wstrb_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [63:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [0:(1 << AW) - 1];
  logic [63:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (wstrb_i[i]) mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_bram_slave.sv
// AXI4 INCR-burst slave over on-chip RAM with independent read and write engines.
// Define AXI_BRAM_SLAVE_ERRCHK_EN to enable wlast/length checking (SLVERR and sticky err).
module axi_bram_slave
  import rbus_axi_pkg::*;
#(
  parameter int unsigned BURST_BITS     = 256,
  parameter int unsigned MEM_WORDS_LOG2 = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [28:0] S_AXI_awaddr,
  input  logic [7:0]  S_AXI_awlen,
  input  logic [1:0]  S_AXI_awid,
  input  logic        S_AXI_awvalid,
  output logic        S_AXI_awready,
  input  logic [63:0] S_AXI_wdata,
  input  logic [7:0]  S_AXI_wstrb,
  input  logic        S_AXI_wlast,
  input  logic        S_AXI_wvalid,
  output logic        S_AXI_wready,
  output logic [1:0]  S_AXI_bid,
  output logic [1:0]  S_AXI_bresp,
  output logic        S_AXI_bvalid,
  input  logic        S_AXI_bready,
  input  logic [28:0] S_AXI_araddr,
  input  logic [7:0]  S_AXI_arlen,
  input  logic [1:0]  S_AXI_arid,
  input  logic        S_AXI_arvalid,
  output logic        S_AXI_arready,
  output logic [63:0] S_AXI_rdata,
  output logic [1:0]  S_AXI_rid,
  output logic [1:0]  S_AXI_rresp,
  output logic        S_AXI_rlast,
  output logic        S_AXI_rvalid,
  input  logic        S_AXI_rready,
  output logic        err
);

  localparam int unsigned MW          = MEM_WORDS_LOG2;
  localparam logic [7:0]  AXI_LEN_NOM = axi_len_nom(BURST_BITS);

  w_state_t      w_state_q;
  logic [MW-1:0] waddr_q;
  logic [7:0]    wlen_q, wcnt_q;
  logic [1:0]    bid_q, bresp_q;
  logic          awready_q, wready_q, bvalid_q, wslverr_q;

  r_state_t      r_state_q;
  logic [MW-1:0] raddr_q;
  logic [7:0]    rlen_q, rcnt_q;
  logic [1:0]    rid_q;
  logic          arready_q, rvalid_q, rlast_q;

  logic wen, ren, wlast_bad, wbeat_last;

  assign wbeat_last = (wcnt_q == wlen_q);
  assign wen = (w_state_q == W_DATA) && S_AXI_wvalid && !rst;
  // Fetch the next beat whenever the output register is empty or being drained.
  assign ren = (r_state_q == R_DATA) && !rlast_q && (!rvalid_q || S_AXI_rready) && !rst;

`ifdef AXI_BRAM_SLAVE_ERRCHK_EN
  logic err_q;
  assign wlast_bad = (S_AXI_wlast != wbeat_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((awready_q && S_AXI_awvalid && (S_AXI_awlen != AXI_LEN_NOM)) ||
                 (arready_q && S_AXI_arvalid && (S_AXI_arlen != AXI_LEN_NOM)) ||
                 (wen && wlast_bad)) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign wlast_bad = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      bid_q     <= '0;
      bresp_q   <= AXI_RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      wslverr_q <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awready_q && S_AXI_awvalid) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            waddr_q   <= S_AXI_awaddr[MW+2:3];
            wlen_q    <= S_AXI_awlen;
            wcnt_q    <= '0;
            bid_q     <= S_AXI_awid;
            wslverr_q <= 1'b0;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (S_AXI_wvalid) begin
            waddr_q <= waddr_q + 1'b1;
            wcnt_q  <= wcnt_q + 8'd1;
            if (wbeat_last) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= (wslverr_q || wlast_bad) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
              w_state_q <= W_RESP;
            end else begin
              wslverr_q <= wslverr_q || wlast_bad;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_bready) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= AXI_RESP_OKAY;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rid_q     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arready_q && S_AXI_arvalid) begin
            arready_q <= 1'b0;
            raddr_q   <= S_AXI_araddr[MW+2:3];
            rlen_q    <= S_AXI_arlen;
            rcnt_q    <= '0;
            rid_q     <= S_AXI_arid;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid_q && rlast_q && S_AXI_rready) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end else if (ren) begin
            rvalid_q <= 1'b1;
            rlast_q  <= (rcnt_q == rlen_q);
            rcnt_q   <= rcnt_q + 8'd1;
            raddr_q  <= raddr_q + 1'b1;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  axi_bram_dp #(.AW(MW)) u_ram (
    .clk_i   (clk),
    .we_i    (wen),
    .wstrb_i (S_AXI_wstrb),
    .waddr_i (waddr_q),
    .wdata_i (S_AXI_wdata),
    .re_i    (ren),
    .raddr_i (raddr_q),
    .rdata_o (S_AXI_rdata)
  );

  assign S_AXI_awready = awready_q;
  assign S_AXI_wready  = wready_q;
  assign S_AXI_bid     = bid_q;
  assign S_AXI_bresp   = bresp_q;
  assign S_AXI_bvalid  = bvalid_q;
  assign S_AXI_arready = arready_q;
  assign S_AXI_rid     = rid_q;
  assign S_AXI_rresp   = AXI_RESP_OKAY;
  assign S_AXI_rlast   = rlast_q;
  assign S_AXI_rvalid  = rvalid_q;

  // Burst format is fixed INCR/8-byte; address bits outside the word index alias.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_awaddr, S_AXI_araddr, S_AXI_wlast, AXI_LEN_NOM,
                       AXI_BURST_INCR, AXI_SIZE_8B};

endmodule

// File: tb/tb_axi_bram_slave.sv
// Directed self-checking bench for axi_bram_slave (RAM depth 16 words, so 0x100/0x200/0x300 alias word 0).
module tb_axi_bram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [28:0] S_AXI_awaddr, S_AXI_araddr;
  logic [7:0]  S_AXI_awlen, S_AXI_arlen, S_AXI_wstrb;
  logic [1:0]  S_AXI_awid, S_AXI_arid, S_AXI_bid, S_AXI_bresp, S_AXI_rid, S_AXI_rresp;
  logic        S_AXI_awvalid, S_AXI_awready, S_AXI_wlast, S_AXI_wvalid, S_AXI_wready;
  logic        S_AXI_bvalid, S_AXI_bready, S_AXI_arvalid, S_AXI_arready;
  logic        S_AXI_rlast, S_AXI_rvalid, S_AXI_rready, err;
  logic [63:0] S_AXI_wdata, S_AXI_rdata;

  int vectors = 0;
  int fails   = 0;
  int t, beat;

  logic [63:0] wd [4];
  logic [7:0]  ws [4];
  logic        wl [4];
  logic [63:0] ed [4];
  logic        rr [4];

`ifdef AXI_BRAM_SLAVE_ERRCHK_EN
  localparam logic [1:0] BAD_BRESP = 2'b10;
  localparam logic       ERR_EXP   = 1'b1;
`else
  localparam logic [1:0] BAD_BRESP = 2'b00;
  localparam logic       ERR_EXP   = 1'b0;
`endif

  axi_bram_slave #(.BURST_BITS(256), .MEM_WORDS_LOG2(4)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awlen(S_AXI_awlen), .S_AXI_awid(S_AXI_awid),
    .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
    .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb), .S_AXI_wlast(S_AXI_wlast),
    .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready),
    .S_AXI_bid(S_AXI_bid), .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid),
    .S_AXI_bready(S_AXI_bready),
    .S_AXI_araddr(S_AXI_araddr), .S_AXI_arlen(S_AXI_arlen), .S_AXI_arid(S_AXI_arid),
    .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
    .S_AXI_rdata(S_AXI_rdata), .S_AXI_rid(S_AXI_rid), .S_AXI_rresp(S_AXI_rresp),
    .S_AXI_rlast(S_AXI_rlast), .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready),
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [28:0] addr, input logic [1:0] id, input logic [1:0] exp_bresp);
    int n;
    S_AXI_awaddr = addr; S_AXI_awlen = 8'd3; S_AXI_awid = id; S_AXI_awvalid = 1'b1;
    S_AXI_wdata = wd[0]; S_AXI_wstrb = ws[0]; S_AXI_wlast = wl[0]; S_AXI_wvalid = 1'b1;
    chk("wready_before_aw", S_AXI_wready, 1'b0);
    n = 0;
    while (!S_AXI_awready && n < 20) begin tick(); n++; end
    chk("aw_timeout", n < 20, 1'b1);
    tick();
    S_AXI_awvalid = 1'b0;
    chk("wready_n1", S_AXI_wready, 1'b1);
    for (int b = 0; b < 4; b++) begin
      S_AXI_wdata = wd[b]; S_AXI_wstrb = ws[b]; S_AXI_wlast = wl[b]; S_AXI_wvalid = 1'b1;
      n = 0;
      while (!S_AXI_wready && n < 20) begin tick(); n++; end
      tick();
    end
    S_AXI_wvalid = 1'b0; S_AXI_wlast = 1'b0;
    chk("bvalid_n2len", S_AXI_bvalid, 1'b1);
    chk("wready_in_resp", S_AXI_wready, 1'b0);
    chk("bid", S_AXI_bid, id);
    chk("bresp", S_AXI_bresp, exp_bresp);
    S_AXI_bready = 1'b1;
    tick();
    S_AXI_bready = 1'b0;
    chk("bvalid_drop", S_AXI_bvalid, 1'b0);
    chk("awready_after_b", S_AXI_awready, 1'b1);
  endtask

  task automatic do_read(input logic [28:0] addr, input logic [1:0] id);
    int n, cyc, got, first;
    logic stalled, hl;
    logic [63:0] hd;
    S_AXI_araddr = addr; S_AXI_arlen = 8'd3; S_AXI_arid = id; S_AXI_arvalid = 1'b1;
    S_AXI_rready = 1'b0;
    n = 0;
    while (!S_AXI_arready && n < 20) begin tick(); n++; end
    chk("ar_timeout", n < 20, 1'b1);
    tick();
    S_AXI_arvalid = 1'b0;
    cyc = 1; got = 0; first = 0; stalled = 1'b0; hd = '0; hl = 1'b0;
    while (got < 4 && cyc < 60) begin
      S_AXI_rready = rr[(cyc + 2) % 4];
      if (S_AXI_rvalid) begin
        if (first == 0) begin
          first = cyc;
          chk("first_rvalid_latency", cyc, 2);
        end
        if (stalled) begin
          chk("rdata_stall_hold", S_AXI_rdata, hd);
          chk("rlast_stall_hold", S_AXI_rlast, hl);
        end
        if (S_AXI_rready) begin
          chk("rdata", S_AXI_rdata, ed[got]);
          chk("rlast", S_AXI_rlast, got == 3);
          chk("rid", S_AXI_rid, id);
          chk("rresp", S_AXI_rresp, 2'b00);
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hd = S_AXI_rdata;
          hl = S_AXI_rlast;
        end
      end
      tick();
      cyc++;
    end
    S_AXI_rready = 1'b0;
    chk("read_beat_count", got, 4);
    chk("rvalid_after_rlast", S_AXI_rvalid, 1'b0);
    chk("arready_after_rlast", S_AXI_arready, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    S_AXI_awaddr = '0; S_AXI_awlen = '0; S_AXI_awid = '0; S_AXI_awvalid = 1'b0;
    S_AXI_wdata = '0; S_AXI_wstrb = '0; S_AXI_wlast = 1'b0; S_AXI_wvalid = 1'b0;
    S_AXI_bready = 1'b0;
    S_AXI_araddr = '0; S_AXI_arlen = '0; S_AXI_arid = '0; S_AXI_arvalid = 1'b0;
    S_AXI_rready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_awready", S_AXI_awready, 1'b0);
    chk("rst_wready", S_AXI_wready, 1'b0);
    chk("rst_bvalid", S_AXI_bvalid, 1'b0);
    chk("rst_arready", S_AXI_arready, 1'b0);
    chk("rst_rvalid", S_AXI_rvalid, 1'b0);
    chk("rst_rlast", S_AXI_rlast, 1'b0);
    chk("rst_bresp", S_AXI_bresp, 2'b00);
    chk("rst_bid", S_AXI_bid, 2'b00);
    chk("rst_rid", S_AXI_rid, 2'b00);
    chk("rst_rresp", S_AXI_rresp, 2'b00);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    tick();
    chk("awready_after_rst", S_AXI_awready, 1'b1);
    chk("arready_after_rst", S_AXI_arready, 1'b1);

    // Basic 4-beat write and readback at 0x100 (word 0)
    wd = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
           64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    ws = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    wl = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_write(29'h100, 2'd2, 2'b00);
    rr = '{1'b1, 1'b1, 1'b1, 1'b1};
    ed = wd;
    do_read(29'h100, 2'd1);
    chk("err_clean", err, 1'b0);

    // Partial strobe: fill word 0 with ones, then clear its low 4 bytes
    wd = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 64'h0};
    ws = '{8'hFF, 8'h00, 8'h00, 8'h00};
    do_write(29'h200, 2'd3, 2'b00);
    wd = '{64'h0, 64'h0, 64'h0, 64'h0};
    ws = '{8'h0F, 8'h00, 8'h00, 8'h00};
    do_write(29'h200, 2'd0, 2'b00);
    ed = '{64'hFFFF_FFFF_0000_0000, 64'h2222_2222_2222_2222,
           64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    do_read(29'h200, 2'd2);

    // Wrap: burst from word 14 covers 14, 15, 0, 1; word 2 keeps 0x33..
    wd = '{64'hA1A1_A1A1_A1A1_A1A1, 64'hA2A2_A2A2_A2A2_A2A2,
           64'hA3A3_A3A3_A3A3_A3A3, 64'hA4A4_A4A4_A4A4_A4A4};
    ws = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_write(29'h70, 2'd1, 2'b00);
    ed = wd;
    do_read(29'h70, 2'd3);
    ed = '{64'hA3A3_A3A3_A3A3_A3A3, 64'hA4A4_A4A4_A4A4_A4A4,
           64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    do_read(29'h0, 2'd0);

    // Stalled read with rready 1,0,0,1
    rr = '{1'b1, 1'b0, 1'b0, 1'b1};
    ed = '{64'hA1A1_A1A1_A1A1_A1A1, 64'hA2A2_A2A2_A2A2_A2A2,
           64'hA3A3_A3A3_A3A3_A3A3, 64'hA4A4_A4A4_A4A4_A4A4};
    do_read(29'h70, 2'd2);
    rr = '{1'b1, 1'b1, 1'b1, 1'b1};

    // Early wlast, then a clean burst: err must stick
    ws = '{8'h00, 8'h00, 8'h00, 8'h00};
    wl = '{1'b0, 1'b1, 1'b0, 1'b0};
    do_write(29'h300, 2'd1, BAD_BRESP);
    chk("err_after_bad_wlast", err, ERR_EXP);
    wl = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_write(29'h300, 2'd2, 2'b00);
    chk("err_sticky", err, ERR_EXP);

    // Reset in the middle of a read, after beat 2
    S_AXI_araddr = 29'h70; S_AXI_arlen = 8'd3; S_AXI_arid = 2'd1; S_AXI_arvalid = 1'b1;
    S_AXI_rready = 1'b1;
    t = 0;
    while (!S_AXI_arready && t < 20) begin tick(); t++; end
    tick();
    S_AXI_arvalid = 1'b0;
    beat = 0; t = 0;
    while (beat < 2 && t < 20) begin
      if (S_AXI_rvalid) begin
        chk("pre_rst_rdata", S_AXI_rdata, ed[beat]);
        beat++;
      end
      tick();
      t++;
    end
    chk("pre_rst_beats", beat, 2);
    rst = 1'b1;
    tick();
    S_AXI_rready = 1'b0;
    chk("mid_rst_rvalid", S_AXI_rvalid, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    rst = 1'b0;
    tick();
    chk("arready_after_mid_rst", S_AXI_arready, 1'b1);
    chk("awready_after_mid_rst", S_AXI_awready, 1'b1);
    do_read(29'h70, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/axi_bram_slave.md
# axi_bram_slave

AXI4 slave responder backed by on-chip byte-enabled dual-port RAM, answering the fixed-format INCR bursts issued by the rbus memory hub AXI master. It stands in for the DDR controller in simulation and small on-chip configurations, so rbus traffic can be looped through memory without an MCB. Read and write engines are independent and share only the RAM array.

## Interface
- BURST_BITS, 256, nominal burst size; reset value of the length-check reference, AXI_LEN_NOM = BURST_BITS/64-1
- MEM_WORDS_LOG2, 12, RAM depth in 64-bit words
- clk  in  1  clock; everything is synchronous to it
- rst  in  1  reset, synchronous, active-high
- S_AXI_awaddr  in  29  write byte address; bits [2:0] ignored
- S_AXI_awlen  in  8  write beats minus 1
- S_AXI_awid  in  2  write ID; echoed on bid
- S_AXI_awvalid / S_AXI_awready  in / out  1  AW handshake
- S_AXI_wdata  in  64  write data
- S_AXI_wstrb  in  8  byte enables, bit i covers byte i
- S_AXI_wlast  in  1  last write beat marker
- S_AXI_wvalid / S_AXI_wready  in / out  1  W handshake
- S_AXI_bid  out  2  response ID
- S_AXI_bresp  out  2  write response code
- S_AXI_bvalid / S_AXI_bready  out / in  1  B handshake
- S_AXI_araddr  in  29  read byte address; bits [2:0] ignored
- S_AXI_arlen  in  8  read beats minus 1
- S_AXI_arid  in  2  read ID; echoed on rid
- S_AXI_arvalid / S_AXI_arready  in / out  1  AR handshake
- S_AXI_rdata  out  64  read data
- S_AXI_rid, S_AXI_rresp  out  2, 2  read ID, response code (always OKAY)
- S_AXI_rlast  out  1  last read beat
- S_AXI_rvalid / S_AXI_rready  out / in  1  R handshake
- err  out  1  sticky protocol error flag

Burst, size, cache, lock, prot, qos and region inputs are not ports: INCR, 8-byte beats are implied.

## Operation
- Word index = addr[MEM_WORDS_LOG2+2:3]. Upper bits alias. Burst addresses increment by 1 word and wrap modulo 2^MEM_WORDS_LOG2.
- Write FSM:
  - W_IDLE (awready=1): on AW handshake, latch index, awlen and awid; clear beat counter; go to W_DATA.
  - W_DATA (wready=1): each W handshake writes the lanes selected by wstrb. The beat counter reaches awlen, which ends the burst and moves to W_RESP. The counter decides termination, not wlast.
  - W_RESP (bvalid=1): hold until bready, then go to W_IDLE.
- Read FSM:
  - R_IDLE (arready=1): on AR handshake, latch index, arlen and arid; go to R_DATA.
  - R_DATA: RAM read enable = !rvalid | rready. rvalid is held with stable rdata/rlast until rready.
  - After the rlast handshake, go to R_IDLE.
- Read and write to the same word in the same cycle: read-first; the read returns the old contents.
- bresp = OKAY (2'b00) except as set under Configuration.

## Timing
- Reset values: all ready/valid outputs 0, bresp/rresp 0, bid/rid 0, rlast 0, err 0. RAM contents are not reset.
- awready and arready assert on the first cycle after rst deasserts.
- Write: AW handshake at cycle N → wready=1 at N+1. With continuous wvalid, the last beat is at N+1+awlen and bvalid=1 at N+2+awlen.
- Read: AR handshake at cycle N → first rvalid at N+2. With rready held high, beats are back-to-back, one per clock. Stalls insert no bubbles after rready returns.
- arready returns one cycle after the rlast handshake; awready returns one cycle after the B handshake. There is one outstanding burst per direction.
- AW and W are not accepted in the same cycle: W before AW is back-pressured (wready=0 in W_IDLE).
- rst asserted mid-burst aborts both engines immediately. Completed RAM writes persist.

## Configuration
- Macro AXI_BRAM_SLAVE_ERRCHK_EN.
- Defined:
  - A wlast mismatch sets bresp=SLVERR (2'b10) for that burst and sets err. A mismatch is wlast=1 before the final beat, or wlast=0 on the final beat.
  - awlen or arlen ≠ AXI_LEN_NOM also sets err. The burst is still served.
  - err clears only on rst.
- Undefined: no checks; bresp always OKAY and err tied 0.

## Structure
- Shared package rbus_axi_pkg holds:
  - AXI_RESP_OKAY, AXI_RESP_SLVERR
  - AXI_BURST_INCR, AXI_SIZE_8B
  - AXI_LEN_NOM function of BURST_BITS
  - w_state_t {W_IDLE, W_DATA, W_RESP}
  - r_state_t {R_IDLE, R_DATA}
- One sub-module: axi_bram_dp, a simple dual-port RAM with one write port (8 byte enables) and one read port with read enable. It uses registered output and read-first behaviour.

## Test plan
- Write 4 beats at 0x100 of 0x11..11, 0x22..22, 0x33..33, 0x44..44 with full strobes, then read 4 beats at 0x100. Required: data returned in order, rlast on beat 4, bresp=0, first rvalid 2 cycles after AR.
- Partial strobe: word 0x200 holds 0xFFFF_FFFF_FFFF_FFFF; write 0x0 with wstrb=8'h0F. A read then returns 0xFFFF_FFFF_0000_0000.
- Wrap: with MEM_WORDS_LOG2=4, write 4 beats at word 14. Required: words 14, 15, 0, 1 written; word 2 untouched.
- Stall: read 4 beats with rready toggling 1,0,0,1,... Required: rdata and rlast stable while stalled; all 4 beats delivered exactly once.
- Error check (macro defined): a 4-beat write with wlast on beat 2 gives bresp=2'b10 and err=1. err stays 1 until rst.
- Reset mid-read after beat 2: rvalid=0 the next cycle and arready=1 the cycle after rst drops. A new 4-beat read then completes normally.
